// File: rtl/mem_stage.sv
// Memory-access stage: waits for data-SRAM responses, extracts/extends load data,
// forwards results to decode and hands completed instructions to writeback.
// After a writeback flush it drops the responses still owed to flushed loads/stores.
module mem_stage #(
    parameter int unsigned DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    output logic        mem_allowin,
    input  logic [77:0] ex_mem_bus,
    input  logic        wb_allowin,
    output logic        mem_wb_valid,
    output logic [70:0] mem_wb_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_ex,
    output logic        mem_ex,
    output logic [38:0] mem_id_bus
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned HALF_W   = 16;
    localparam int unsigned REG_AW   = 5;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // Execute-to-memory payload, MSB first
    typedef struct packed {
        logic              ex_flag;
        logic              req_sent;
        logic              gr_we;
        logic              res_from_mem;
        logic [2:0]        mem_type;
        logic [1:0]        addr_low2;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] result;
    } ex_mem_t;

    ex_mem_t               bus_r;
    logic                  mem_valid;
    logic                  data_buf_vld;
    logic [DATA_W-1:0]     data_buf;
    logic [DISCARD_W-1:0]  discard_cnt;

    logic                  discard_idle;
    logic                  discard_full;
    logic                  resp_mine;
    logic                  need_data;
    logic                  ready_go;
    logic                  accept;
    logic                  discard_inc;
    logic                  discard_dec;

    logic [DATA_W-1:0]     raw_data;
    logic [BYTE_W-1:0]     byte_sel;
    logic [HALF_W-1:0]     half_sel;
    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     final_result;
    logic                  bypass_vld;
    logic                  load_pending;

    // Handshake and response-ownership decode
    always_comb begin
        discard_idle = (discard_cnt == '0);
        discard_full = (discard_cnt == {DISCARD_W{1'b1}});
        // With nothing left to discard, the next response belongs to the occupant
        resp_mine    = data_sram_data_ok & discard_idle;
        need_data    = mem_valid & bus_r.req_sent & ~data_buf_vld;
        ready_go     = ~need_data | resp_mine;
        mem_allowin  = ~mem_valid | (ready_go & wb_allowin);
        accept       = ex_mem_valid & mem_allowin & ~wb_ex;
        // A flushed occupant still owes its response unless it is being consumed right now;
        // a response arriving while discards are pending is a stale one, not the occupant's
        discard_inc  = wb_ex & need_data & ~resp_mine;
        discard_dec  = data_sram_data_ok & ~discard_idle;
    end

    // Occupancy: flush wins over accept; a free stage with no offer empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (wb_ex) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= ex_mem_valid;
        end
    end

    // Instruction payload captured on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_r <= '0;
        end else if (accept) begin
            bus_r <= ex_mem_t'(ex_mem_bus);
        end
    end

    // Hold a response that arrives while writeback is stalled (only one is ever owed)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_buf_vld <= 1'b0;
            data_buf     <= '0;
        end else if (accept) begin
            data_buf_vld <= 1'b0;
        end else if (need_data & resp_mine & ~wb_allowin) begin
            data_buf_vld <= 1'b1;
            data_buf     <= data_sram_rdata;
        end
    end

    // Count of responses still owed to flushed instructions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (discard_inc & ~discard_dec) begin
            if (!discard_full) begin
                discard_cnt <= discard_cnt + DISCARD_W'(1);
            end
        end else if (discard_dec & ~discard_inc) begin
            discard_cnt <= discard_cnt - DISCARD_W'(1);
        end
    end

`ifndef SYNTHESIS
    // Overflowing the discard counter would lose track of an owed response
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(discard_inc && !discard_dec && discard_full))
                else $error("mem_stage: discard counter saturated, owed response lost");
        end
    end
`endif

    // Byte/half lane selection from the raw or buffered response
    always_comb begin
        raw_data = data_buf_vld ? data_buf : data_sram_rdata;
        byte_sel = '0;
        case (bus_r.addr_low2)
            2'b00:   byte_sel = raw_data[7:0];
            2'b01:   byte_sel = raw_data[15:8];
            2'b10:   byte_sel = raw_data[23:16];
            default: byte_sel = raw_data[31:24];
        endcase
        half_sel = bus_r.addr_low2[1] ? raw_data[31:16] : raw_data[15:0];
    end

    // Zero/sign extension by access size
    always_comb begin
        load_data = raw_data;
        case (bus_r.mem_type[1:0])
            SIZE_BYTE: load_data = bus_r.mem_type[2]
                                   ? {{(DATA_W-BYTE_W){1'b0}}, byte_sel}
                                   : {{(DATA_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            SIZE_HALF: load_data = bus_r.mem_type[2]
                                   ? {{(DATA_W-HALF_W){1'b0}}, half_sel}
                                   : {{(DATA_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            default:   load_data = raw_data;
        endcase
    end

    // Result selection and outward buses
    always_comb begin
        final_result = bus_r.res_from_mem ? load_data : bus_r.result;
        mem_wb_valid = mem_valid & ready_go;
        mem_ex       = mem_valid & bus_r.ex_flag;
        bypass_vld   = mem_valid & bus_r.gr_we & ~bus_r.ex_flag & ready_go;
        load_pending = mem_valid & bus_r.res_from_mem & ~ready_go;
        mem_wb_bus   = {bus_r.gr_we, bus_r.dest, bus_r.pc, final_result, bus_r.ex_flag};
        mem_id_bus   = {bypass_vld, load_pending, bus_r.dest, final_result};
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios, then a randomized run against a
// transaction-level model that tracks which instruction owns each SRAM response.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_mem_valid;
    logic        mem_allowin;
    logic [77:0] ex_mem_bus;
    logic        wb_allowin;
    logic        mem_wb_valid;
    logic [70:0] mem_wb_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_ex;
    logic        mem_ex;
    logic [38:0] mem_id_bus;

    int checks = 0;
    int errors = 0;

    // Model state: current occupant and in-order queue of owed responses
    bit          occ;
    bit          occ_got;
    int          occ_id;
    int          next_id;
    logic [77:0] occ_bus;
    logic [31:0] occ_buf;
    int          rq_id[$];
    logic [31:0] rq_data[$];
    int          rq_wait[$];

    bit          resp_occ;
    bit          e_valid;
    bit          e_allow;
    logic [31:0] e_raw;
    logic [31:0] e_final;

    mem_stage #(.DISCARD_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_mem_valid      (ex_mem_valid),
        .mem_allowin       (mem_allowin),
        .ex_mem_bus        (ex_mem_bus),
        .wb_allowin        (wb_allowin),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_bus        (mem_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .mem_ex            (mem_ex),
        .mem_id_bus        (mem_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [77:0] obs, input logic [77:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [77:0] mk(input logic ef, input logic rs, input logic we,
                                       input logic rfm, input logic [2:0] mt,
                                       input logic [1:0] al, input logic [4:0] dst,
                                       input logic [31:0] pc, input logic [31:0] res);
        return {ef, rs, we, rfm, mt, al, dst, pc, res};
    endfunction

    // Load value from architectural rules: shift the lane down, mask, then sign-adjust
    function automatic logic [31:0] ref_final(input logic [77:0] b, input logic [31:0] raw);
        longint v;
        bit     zx;
        if (!b[74]) return b[31:0];
        zx = b[73];
        case (b[72:71])
            2'b00: begin
                v = (longint'(raw) >> (8 * int'(b[70:69]))) & 64'hFF;
                if (!zx && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = (longint'(raw) >> (16 * int'(b[70]))) & 64'hFFFF;
                if (!zx && v >= 32768) v = v - 65536;
            end
            default: v = longint'(raw);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [77:0] rand_bus();
        logic       ef, rs, rfm, zx;
        logic [1:0] sz, al;
        ef  = ($urandom_range(7) == 0);
        rfm = 1'($urandom_range(1));
        rs  = ef ? 1'b0 : (rfm ? 1'b1 : 1'($urandom_range(1)));
        zx  = 1'($urandom_range(1));
        case ($urandom_range(2))
            0:       sz = 2'b00;
            1:       sz = 2'b01;
            default: sz = 2'b11;
        endcase
        al = 2'($urandom_range(3));
        return mk(ef, rs, 1'($urandom_range(1)), rfm, {zx, sz}, al,
                  5'($urandom_range(31)), $urandom(), $urandom());
    endfunction

    task automatic idle();
        ex_mem_valid      = 1'b0;
        ex_mem_bus        = '0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        wb_ex             = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk1("rst_allowin", mem_allowin, 1'b1);
        chk1("rst_wb_valid", mem_wb_valid, 1'b0);
        chk1("rst_mem_ex", mem_ex, 1'b0);
        chk1("rst_bypass", mem_id_bus[38], 1'b0);
        chk1("rst_load_pending", mem_id_bus[37], 1'b0);
        reset = 1'b0;

        // ALU op passes straight through
        @(negedge clk);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 0, 1, 0, 3'b011, 2'b00, 5'd5, 32'h1c00_0000, 32'h1234_5678);
        #1 chk1("alu_allowin", mem_allowin, 1'b1);
        @(negedge clk);
        idle();
        #1;
        chk1("alu_wb_valid", mem_wb_valid, 1'b1);
        chkw("alu_result", 78'(mem_wb_bus[32:1]), 78'(32'h1234_5678));
        chk1("alu_bypass", mem_id_bus[38], 1'b1);
        @(negedge clk);
        #1 chk1("alu_drained", mem_wb_valid, 1'b0);

        // ld.b at byte 3, response two cycles after accept
        @(negedge clk);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 1, 1, 1, 3'b000, 2'b11, 5'd7, 32'h1c00_0010, 32'h0000_1003);
        @(negedge clk);
        idle();
        #1;
        chk1("ldb_pending_c1", mem_id_bus[37], 1'b1);
        chk1("ldb_wait_valid", mem_wb_valid, 1'b0);
        chk1("ldb_wait_allowin", mem_allowin, 1'b0);
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_FFFF;
        #1;
        chk1("ldb_valid", mem_wb_valid, 1'b1);
        chkw("ldb_result", 78'(mem_wb_bus[32:1]), 78'(32'hFFFF_FF80));
        chk1("ldb_pending_c2", mem_id_bus[37], 1'b0);
        chkw("ldb_fwd", 78'(mem_id_bus[31:0]), 78'(32'hFFFF_FF80));
        @(negedge clk);
        idle();
        #1 chk1("ldb_drained", mem_wb_valid, 1'b0);

        // ld.hu with writeback stalled for three cycles: response is buffered
        @(negedge clk);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 1, 1, 1, 3'b101, 2'b10, 5'd9, 32'h1c00_0020, 32'h0000_2002);
        @(negedge clk);
        idle();
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        #1;
        chk1("ldhu_valid_c1", mem_wb_valid, 1'b1);
        chkw("ldhu_result_c1", 78'(mem_wb_bus[32:1]), 78'(32'h0000_BEEF));
        chk1("ldhu_stall_allowin", mem_allowin, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h1357_9BDF;
            #1;
            chk1("ldhu_hold_valid", mem_wb_valid, 1'b1);
            chkw("ldhu_hold_result", 78'(mem_wb_bus[32:1]), 78'(32'h0000_BEEF));
        end
        @(negedge clk);
        wb_allowin = 1'b1;
        #1;
        chk1("ldhu_release_valid", mem_wb_valid, 1'b1);
        chkw("ldhu_release_result", 78'(mem_wb_bus[32:1]), 78'(32'h0000_BEEF));
        chk1("ldhu_release_allowin", mem_allowin, 1'b1);
        @(negedge clk);
        idle();
        #1 chk1("ldhu_drained", mem_wb_valid, 1'b0);

        // Flush a waiting load, then discard its late response
        @(negedge clk);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 1, 1, 1, 3'b011, 2'b00, 5'd3, 32'h1c00_0030, 32'h0000_3000);
        @(negedge clk);
        idle();
        wb_ex = 1'b1;
        #1 chk1("flush_pending", mem_id_bus[37], 1'b1);
        @(negedge clk);
        idle();
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 1, 1, 1, 3'b011, 2'b00, 5'd4, 32'h1c00_0040, 32'h0000_4000);
        #1;
        chk1("flush_allowin", mem_allowin, 1'b1);
        chk1("flush_empty", mem_wb_valid, 1'b0);
        @(negedge clk);
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk1("discard_ignored", mem_wb_valid, 1'b0);
        chk1("discard_pending", mem_id_bus[37], 1'b1);
        @(negedge clk);
        idle();
        #1 chk1("discard_gap", mem_wb_valid, 1'b0);
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0042;
        #1;
        chk1("discard_deliver_valid", mem_wb_valid, 1'b1);
        chkw("discard_deliver_result", 78'(mem_wb_bus[32:1]), 78'(32'h0000_0042));
        @(negedge clk);
        idle();

        // Excepting instruction passes without a response
        @(negedge clk);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(1, 0, 1, 1, 3'b011, 2'b00, 5'd6, 32'h1c00_0050, 32'h0000_5001);
        @(negedge clk);
        idle();
        #1;
        chk1("ex_mem_ex", mem_ex, 1'b1);
        chk1("ex_bypass", mem_id_bus[38], 1'b0);
        chk1("ex_valid", mem_wb_valid, 1'b1);
        chk1("ex_flag_bus", mem_wb_bus[0], 1'b1);
        chk1("ex_no_pending", mem_id_bus[37], 1'b0);
        @(negedge clk);
        idle();

        // Reset while a load waits behind one pending discard
        @(negedge clk);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 1, 1, 1, 3'b011, 2'b00, 5'd1, 32'h1c00_0060, 32'h0000_6000);
        @(negedge clk);
        idle();
        wb_ex = 1'b1;
        @(negedge clk);
        idle();
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 1, 1, 1, 3'b011, 2'b00, 5'd2, 32'h1c00_0064, 32'h0000_6004);
        @(negedge clk);
        idle();
        #1 chk1("rstmid_pending_before", mem_id_bus[37], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("rstmid_allowin", mem_allowin, 1'b1);
        chk1("rstmid_wb_valid", mem_wb_valid, 1'b0);
        chk1("rstmid_pending", mem_id_bus[37], 1'b0);
        chk1("rstmid_mem_ex", mem_ex, 1'b0);
        @(negedge clk);
        reset        = 1'b0;
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk(0, 1, 1, 1, 3'b011, 2'b00, 5'd8, 32'h1c00_0070, 32'h0000_7000);
        @(negedge clk);
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0077;
        #1;
        chk1("rstmid_no_discard_valid", mem_wb_valid, 1'b1);
        chkw("rstmid_no_discard_result", 78'(mem_wb_bus[32:1]), 78'(32'h0000_0077));
        @(negedge clk);
        idle();

        // Randomized run against the response-ownership model
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        occ     = 1'b0;
        occ_got = 1'b0;
        next_id = 0;
        rq_id.delete();
        rq_data.delete();
        rq_wait.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ex_mem_valid      = ($urandom_range(3) != 0);
            ex_mem_bus        = rand_bus();
            wb_allowin        = ($urandom_range(3) != 0);
            wb_ex             = ($urandom_range(15) == 0) && (rq_id.size() < 3);
            data_sram_data_ok = (rq_id.size() > 0) && (rq_wait[0] == 0);
            data_sram_rdata   = data_sram_data_ok ? rq_data[0] : $urandom();

            resp_occ = data_sram_data_ok && occ && (rq_id[0] == occ_id);
            e_valid  = occ && (!occ_bus[76] || occ_got || resp_occ);
            e_allow  = !occ || (e_valid && wb_allowin);
            e_raw    = occ_got ? occ_buf : data_sram_rdata;
            e_final  = ref_final(occ_bus, e_raw);

            #1;
            chk1("rnd_wb_valid", mem_wb_valid, e_valid);
            chk1("rnd_allowin", mem_allowin, e_allow);
            chk1("rnd_mem_ex", mem_ex, occ && occ_bus[77]);
            chk1("rnd_bypass", mem_id_bus[38], e_valid && occ_bus[75] && !occ_bus[77]);
            chk1("rnd_load_pending", mem_id_bus[37], occ && occ_bus[74] && !e_valid);
            if (e_valid) begin
                chkw("rnd_wb_bus", 78'(mem_wb_bus),
                     78'({occ_bus[75], occ_bus[68:64], occ_bus[63:32], e_final, occ_bus[77]}));
                chkw("rnd_fwd", 78'(mem_id_bus[36:0]), 78'({occ_bus[68:64], e_final}));
            end

            if (data_sram_data_ok) begin
                void'(rq_id.pop_front());
                void'(rq_data.pop_front());
                void'(rq_wait.pop_front());
            end else if (rq_id.size() > 0 && rq_wait[0] > 0) begin
                rq_wait[0] = rq_wait[0] - 1;
            end

            if (wb_ex) begin
                occ = 1'b0;
            end else if (e_allow) begin
                if (ex_mem_valid) begin
                    occ     = 1'b1;
                    occ_id  = next_id;
                    next_id = next_id + 1;
                    occ_bus = ex_mem_bus;
                    occ_got = 1'b0;
                    if (ex_mem_bus[76]) begin
                        rq_id.push_back(occ_id);
                        rq_data.push_back($urandom());
                        rq_wait.push_back(int'($urandom_range(3)));
                    end
                end else begin
                    occ = 1'b0;
                end
            end else if (resp_occ) begin
                occ_got = 1'b1;
                occ_buf = data_sram_rdata;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
